// File: rtl/clk_wiz_lock_sequencer.sv
// Lock qualifier and staged reset sequencer for the clock wizard outputs.
// Qualifies PLL lock, opens the clock gates, then releases domain resets in order.

module clk_wiz_rst_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic set,
  output logic q_n
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   q_n <= 1'b0;
    else if (clr) q_n <= 1'b0;
    else if (set) q_n <= 1'b1;
endmodule

module clk_wiz_lock_sequencer #(
  parameter int unsigned N_DOMAINS       = 6,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned LOCK_STABLE_CYC = 1024,
  parameter int unsigned GATE_SETTLE_CYC = 16,
  parameter int unsigned STAGE_GAP_CYC   = 8,
  parameter int unsigned FAULT_HOLD_CYC  = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                 clk_in1,
  input  logic                 resetn,
  input  logic                 locked,
  input  logic                 en,
  input  logic                 clr_fault,
  output logic                 clk_gate_en,
  output logic [N_DOMAINS-1:0] rst_out_n,
  output logic                 ready,
  output logic                 lock_lost,
  output logic [CNT_W-1:0]     relock_count,
  output logic [2:0]           state_o
);
  localparam int unsigned REL_SPAN = (N_DOMAINS - 1) * STAGE_GAP_CYC;
  localparam int unsigned MAX_A    = (LOCK_STABLE_CYC > GATE_SETTLE_CYC) ? LOCK_STABLE_CYC : GATE_SETTLE_CYC;
  localparam int unsigned MAX_B    = (REL_SPAN > FAULT_HOLD_CYC) ? REL_SPAN : FAULT_HOLD_CYC;
  localparam int unsigned MAX_CYC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW       = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_STABLE_CYC - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(GATE_SETTLE_CYC - 1);
  localparam logic [TW-1:0] REL_LAST    = TW'((N_DOMAINS > 1) ? REL_SPAN - 1 : 0);
  localparam logic [TW-1:0] FAULT_LAST  = TW'(FAULT_HOLD_CYC - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    GATE_SETTLE = 3'd1,
    RELEASE     = 3'd2,
    RUN         = 3'd3,
    FAULT       = 3'd4
  } state_t;

  state_t                 state_q, state_nxt;
  logic [TW-1:0]          tmr_q, tmr_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   gate_nxt, ready_nxt, lost_nxt;
  logic [CNT_W-1:0]       relock_nxt;
  logic                   tear, rel_go;

  always_ff @(posedge clk_in1 or negedge resetn)
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], locked};

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt  = state_q;
    tmr_nxt    = tmr_q;
    gate_nxt   = clk_gate_en;
    ready_nxt  = ready;
    lost_nxt   = lock_lost;
    relock_nxt = relock_count;
    tear       = 1'b0;
    rel_go     = 1'b0;
    if (clr_fault) lost_nxt = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (!locked_s || !en) tmr_nxt = '0;
        else if (tmr_q == LOCK_LAST) begin
          state_nxt = GATE_SETTLE;
          tmr_nxt   = '0;
          gate_nxt  = 1'b1;
        end else tmr_nxt = tmr_q + TW'(1);
      end
      GATE_SETTLE, RELEASE, RUN: begin
        // lock loss is checked first so it wins over a simultaneous en drop
        if (!locked_s) begin
          tear      = 1'b1;
          state_nxt = FAULT;
          tmr_nxt   = '0;
          gate_nxt  = 1'b0;
          ready_nxt = 1'b0;
          lost_nxt  = 1'b1;
          if (relock_count != {CNT_W{1'b1}}) relock_nxt = relock_count + CNT_W'(1);
        end else if (!en) begin
          tear      = 1'b1;
          state_nxt = WAIT_LOCK;
          tmr_nxt   = '0;
          gate_nxt  = 1'b0;
          ready_nxt = 1'b0;
        end else if (state_q == GATE_SETTLE) begin
          if (tmr_q == SETTLE_LAST) begin
            rel_go  = 1'b1;
            tmr_nxt = '0;
            if (N_DOMAINS == 1) begin
              state_nxt = RUN;
              ready_nxt = 1'b1;
            end else state_nxt = RELEASE;
          end else tmr_nxt = tmr_q + TW'(1);
        end else if (state_q == RELEASE) begin
          if (tmr_q == REL_LAST) begin
            state_nxt = RUN;
            tmr_nxt   = '0;
            ready_nxt = 1'b1;
          end else tmr_nxt = tmr_q + TW'(1);
        end
      end
      FAULT: begin
        if (tmr_q == FAULT_LAST) begin
          state_nxt = WAIT_LOCK;
          tmr_nxt   = '0;
        end else tmr_nxt = tmr_q + TW'(1);
      end
      default: begin
        state_nxt = WAIT_LOCK;
        tmr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in1 or negedge resetn)
    if (!resetn) begin
      state_q      <= WAIT_LOCK;
      tmr_q        <= '0;
      clk_gate_en  <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      relock_count <= '0;
    end else begin
      state_q      <= state_nxt;
      tmr_q        <= tmr_nxt;
      clk_gate_en  <= gate_nxt;
      ready        <= ready_nxt;
      lock_lost    <= lost_nxt;
      relock_count <= relock_nxt;
    end

  assign state_o = state_q;

  // domain k releases (k*STAGE_GAP_CYC - 1) cycles into RELEASE, landing k gaps after bit 0
  for (genvar k = 0; k < N_DOMAINS; k++) begin : g_dom
    logic set_k;
    if (k == 0) begin : g_first
      assign set_k = rel_go;
    end else begin : g_rest
      localparam logic [TW-1:0] REL_AT = TW'(k * STAGE_GAP_CYC - 1);
      assign set_k = (state_q == RELEASE) && (tmr_q == REL_AT) && !tear && en;
    end
    clk_wiz_rst_stage u_stage (
      .clk   (clk_in1),
      .rst_n (resetn),
      .clr   (tear),
      .set   (set_k),
      .q_n   (rst_out_n[k])
    );
  end
endmodule

// File: tb/tb_clk_wiz_lock_sequencer.sv
// Directed bench for clk_wiz_lock_sequencer with short timing parameters.
// Cycle c after locked_s first goes high is observed c+2 ticks after locked is driven.

module tb_clk_wiz_lock_sequencer;
  localparam int ND = 3;
  localparam int CW = 8;

  logic          clk_in1 = 1'b0;
  logic          resetn, locked, en, clr_fault;
  logic          clk_gate_en, ready, lock_lost;
  logic [ND-1:0] rst_out_n;
  logic [CW-1:0] relock_count;
  logic [2:0]    state_o;

  int checks = 0;
  int errors = 0;

  clk_wiz_lock_sequencer #(
    .N_DOMAINS(ND), .SYNC_STAGES(2), .LOCK_STABLE_CYC(4), .GATE_SETTLE_CYC(2),
    .STAGE_GAP_CYC(3), .FAULT_HOLD_CYC(5), .CNT_W(CW)
  ) dut (
    .clk_in1      (clk_in1),
    .resetn       (resetn),
    .locked       (locked),
    .en           (en),
    .clr_fault    (clr_fault),
    .clk_gate_en  (clk_gate_en),
    .rst_out_n    (rst_out_n),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .relock_count (relock_count),
    .state_o      (state_o)
  );

  always #5 clk_in1 = ~clk_in1;

  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic g, input logic [ND-1:0] r, input logic rd,
                         input logic ll, input logic [CW-1:0] rc, input logic [2:0] st);
    chk({tag, ".gate"},   32'(clk_gate_en),  32'(g));
    chk({tag, ".rst"},    32'(rst_out_n),    32'(r));
    chk({tag, ".ready"},  32'(ready),        32'(rd));
    chk({tag, ".lost"},   32'(lock_lost),    32'(ll));
    chk({tag, ".relock"}, 32'(relock_count), 32'(rc));
    chk({tag, ".state"},  32'(state_o),      32'(st));
  endtask

  task automatic wait_gate();
    int n = 0;
    while (!clk_gate_en && n < 40) begin tick(); n++; end
    chk("gate_wait", 32'(clk_gate_en), 32'd1);
  endtask

  task automatic wait_fault();
    int n = 0;
    while (state_o != 3'd4 && n < 20) begin tick(); n++; end
    chk("fault_wait", 32'(state_o), 32'd4);
  endtask

  initial begin
    resetn = 1'b0; locked = 1'b0; en = 1'b0; clr_fault = 1'b0;
    repeat (2) tick();
    chk_all("reset", 1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 3'd0);
    resetn = 1'b1;
    tick();

    // 1: clean bring-up
    en = 1'b1; locked = 1'b1;
    repeat (5) tick();
    chk_all("t1.c3", 1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 3'd0);
    tick();
    chk_all("t1.c4", 1'b1, 3'b000, 1'b0, 1'b0, 8'd0, 3'd1);
    tick();
    chk_all("t1.c5", 1'b1, 3'b000, 1'b0, 1'b0, 8'd0, 3'd1);
    tick();
    chk_all("t1.c6", 1'b1, 3'b001, 1'b0, 1'b0, 8'd0, 3'd2);
    repeat (2) tick();
    chk("t1.c8.rst", 32'(rst_out_n), 32'b001);
    tick();
    chk("t1.c9.rst", 32'(rst_out_n), 32'b011);
    repeat (2) tick();
    chk_all("t1.c11", 1'b1, 3'b011, 1'b0, 1'b0, 8'd0, 3'd2);
    tick();
    chk_all("t1.c12", 1'b1, 3'b111, 1'b1, 1'b0, 8'd0, 3'd3);
    repeat (3) tick();
    chk_all("t1.hold", 1'b1, 3'b111, 1'b1, 1'b0, 8'd0, 3'd3);

    // 3: lock loss in RUN
    locked = 1'b0;
    repeat (2) tick();
    chk_all("t3.pre", 1'b1, 3'b111, 1'b1, 1'b0, 8'd0, 3'd3);
    tick();
    chk_all("t3.loss", 1'b0, 3'b000, 1'b0, 1'b1, 8'd1, 3'd4);
    repeat (4) tick();
    chk("t3.f4.state", 32'(state_o), 32'd4);
    tick();
    chk_all("t3.rearm", 1'b0, 3'b000, 1'b0, 1'b1, 8'd1, 3'd0);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    chk_all("t3.clr", 1'b0, 3'b000, 1'b0, 1'b0, 8'd1, 3'd0);

    // 2: one-cycle glitch at locked_s cycle 2
    locked = 1'b1;
    repeat (2) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    repeat (3) tick();
    chk("t2.c4.gate", 32'(clk_gate_en), 32'd0);
    repeat (2) tick();
    chk("t2.c6.gate", 32'(clk_gate_en), 32'd0);
    tick();
    chk_all("t2.c7", 1'b1, 3'b000, 1'b0, 1'b0, 8'd1, 3'd1);

    // 4: en drop during RELEASE with two domains out
    repeat (5) tick();
    chk_all("t4.pre", 1'b1, 3'b011, 1'b0, 1'b0, 8'd1, 3'd2);
    en = 1'b0;
    tick();
    chk_all("t4.off", 1'b0, 3'b000, 1'b0, 1'b0, 8'd1, 3'd0);

    // 5a: lock loss and en drop in the same cycle
    en = 1'b1;
    wait_gate();
    repeat (8) tick();
    chk_all("t5.run", 1'b1, 3'b111, 1'b1, 1'b0, 8'd1, 3'd3);
    locked = 1'b0;
    repeat (2) tick();
    en = 1'b0;
    tick();
    chk_all("t5.both", 1'b0, 3'b000, 1'b0, 1'b1, 8'd2, 3'd4);

    // 5b: clr_fault coincident with a new loss
    en = 1'b1; locked = 1'b1;
    wait_gate();
    chk("t5b.state", 32'(state_o), 32'd1);
    locked = 1'b0;
    repeat (2) tick();
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    chk_all("t5b.loss", 1'b0, 3'b000, 1'b0, 1'b1, 8'd3, 3'd4);
    tick();
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    chk_all("t5b.clr", 1'b0, 3'b000, 1'b0, 1'b0, 8'd3, 3'd4);

    // 5c: relock_count saturation
    for (int i = 0; i < 252; i++) begin
      locked = 1'b1;
      wait_gate();
      locked = 1'b0;
      wait_fault();
    end
    chk("t5c.cnt255", 32'(relock_count), 32'd255);
    locked = 1'b1;
    wait_gate();
    locked = 1'b0;
    wait_fault();
    chk("t5c.sat", 32'(relock_count), 32'd255);
    chk("t5c.lost", 32'(lock_lost), 32'd1);

    // 6: async reset mid-RELEASE
    locked = 1'b1;
    wait_gate();
    repeat (5) tick();
    chk("t6.pre.rst", 32'(rst_out_n), 32'b011);
    #3 resetn = 1'b0;
    #1;
    chk_all("t6.async", 1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 3'd0);
    tick();
    resetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
